// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_unit_pkg                                              |
// | Brief    : Shared encodings and constants for the HI/LO mul/div unit.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mul_div_unit_pkg;

    // Command encodings on mul_con / div_con (2'b11 is reserved and ignored)
    localparam logic [1:0] CON_NONE     = 2'b00;
    localparam logic [1:0] CON_SIGNED   = 2'b01;
    localparam logic [1:0] CON_UNSIGNED = 2'b10;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // One quotient bit per step; tied to the 32-bit operand width
    localparam int DIV_STEPS = 32;

    // LO value reported for any division by zero
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    // A command is live only for the signed/unsigned codes
    function automatic logic con_valid(input logic [1:0] con);
        return (con != CON_NONE) && (con != (CON_SIGNED | CON_UNSIGNED));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_unit_div_iter                                         |
// | Brief    : Radix-2 restoring divider on unsigned magnitudes, one         |
// |            quotient bit per cycle, MSB first, DIV_STEPS steps.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul_div_unit_div_iter
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam int              CNT_W    = $clog2(DIV_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [32:0]      w_shift;
    logic [32:0]      w_diff;

    // Partial remainder shifted left with the next dividend bit; a clear
    // borrow bit in the trial subtraction means the divisor fits.
    assign w_shift = {rem_q, quo_q[31]};
    assign w_diff  = w_shift - {1'b0, dvs_q};

    // Next-state: abort beats start, start beats stepping
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort_i) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CNT_LOAD;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!w_diff[32]) begin
                rem_d = w_diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = w_shift[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d  = cnt_q - CNT_ONE;
            busy_d = (cnt_q != CNT_ONE);
        end
    end

    // Shift registers and step counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done_o flags the cycle whose closing edge performs the final step, so
    // the owner can move on in lockstep with the last quotient bit.
    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == CNT_ONE);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_unit                                                  |
// | Brief    : HI/LO multiply/divide unit. Multiply completes after MUL_LAT  |
// |            busy cycles; divide takes 32 restoring steps plus one sign-   |
// |            fix cycle. Owns HI/LO and services MTHI/MTLO while idle.      |
// |            Optional macro MULDIV_CANCEL_EN adds a cancel input that      |
// |            abandons an in-flight operation without touching HI/LO.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MUL_LAT = 2
)(
    input  logic        clk,
    input  logic        resetn,
`ifdef MULDIV_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [1:0]  mul_con,
    input  logic [1:0]  div_con,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] MUL_LAST = 2'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_sgn_q, mul_sgn_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dzero_q, dzero_d;
    logic [31:0] drs_q, drs_d;

    logic        w_cancel;
    logic        w_idle;
    logic        w_acc_mul;
    logic        w_acc_div;
    logic        w_div_sgn;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_div_busy;
    logic        w_div_last;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_lo;
    logic [31:0] w_fix_hi;

`ifdef MULDIV_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // Acceptance: only from IDLE; multiply wins a same-cycle collision
    assign w_idle    = (state_q == ST_IDLE);
    assign w_acc_mul = w_idle && con_valid(mul_con);
    assign w_acc_div = w_idle && con_valid(div_con) && !con_valid(mul_con);

    // Divider works on magnitudes; signs are remembered for the FIX cycle
    assign w_div_sgn = (div_con == CON_SIGNED);
    assign w_rs_neg  = w_div_sgn && rs[31];
    assign w_rt_neg  = w_div_sgn && rt[31];
    assign w_rs_mag  = w_rs_neg ? (32'd0 - rs) : rs;
    assign w_rt_mag  = w_rt_neg ? (32'd0 - rt) : rt;

    // Extending to 64 bits makes signed and unsigned share one multiplier;
    // the low 64 bits of the product are all that HI/LO keep.
    assign w_a64  = {{32{mul_sgn_q & mul_a_q[31]}}, mul_a_q};
    assign w_b64  = {{32{mul_sgn_q & mul_b_q[31]}}, mul_b_q};
    assign w_prod = w_a64 * w_b64;

    mul_div_unit_div_iter u_div_iter (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (w_acc_div),
        .abort_i     (w_cancel && (state_q == ST_DIV)),
        .dividend_i  (w_rs_mag),
        .divisor_i   (w_rt_mag),
        .busy_o      (w_div_busy),
        .done_o      (w_div_last),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    // Sign correction; divide by zero overrides with the fixed result
    assign w_fix_lo = dzero_q ? DIV_ZERO_LO : (qneg_q ? (32'd0 - w_quo) : w_quo);
    assign w_fix_hi = dzero_q ? drs_q       : (rneg_q ? (32'd0 - w_rem) : w_rem);

    // Next-state and HI/LO update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_sgn_d = mul_sgn_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dzero_d   = dzero_q;
        drs_d     = drs_q;
        case (state_q)
            ST_IDLE: begin
                if (w_acc_mul) begin
                    state_d   = ST_MUL;
                    cnt_d     = MUL_LAST;
                    mul_a_d   = rs;
                    mul_b_d   = rt;
                    mul_sgn_d = (mul_con == CON_SIGNED);
                end else if (w_acc_div) begin
                    state_d = ST_DIV;
                    qneg_d  = w_rs_neg ^ w_rt_neg;
                    rneg_d  = w_rs_neg;
                    dzero_d = (rt == 32'd0);
                    drs_d   = rs;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_MUL: begin
                if (w_cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_DIV: begin
                if (w_cancel) begin
                    state_d = ST_IDLE;
                end else if (w_div_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!w_cancel) begin
                    hi_d   = w_fix_hi;
                    lo_d   = w_fix_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, HI/LO and operand registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_sgn_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dzero_q   <= 1'b0;
            drs_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_sgn_q <= mul_sgn_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dzero_q   <= dzero_d;
            drs_q     <= drs_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE) || w_div_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_div_unit                                               |
// | Brief    : Self-checking bench for mul_div_unit (directed + random ops   |
// |            against an arithmetic reference model). Cancel scenario is    |
// |            compiled in when MULDIV_CANCEL_EN is defined.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mul_div_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        resetn;
    logic        cancel;
    logic [1:0]  mul_con;
    logic [1:0]  div_con;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .resetn  (resetn),
`ifdef MULDIV_CANCEL_EN
        .cancel  (cancel),
`endif
        .mul_con (mul_con),
        .div_con (div_con),
        .rs      (rs),
        .rt      (rt),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: no scenario should come anywhere near this
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {hi, lo} from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] mc, input logic [1:0] dc,
                                          input logic [31:0] a, input logic [31:0] b);
        int          ia, ib, iq, ir;
        longint      lp;
        logic [63:0] ua, ub;
        logic [31:0] q, r;
        ia = $signed(a);
        ib = $signed(b);
        if (mc == 2'b01) begin
            lp = longint'(ia) * longint'(ib);
            return lp;
        end else if (mc == 2'b10) begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            return ua * ub;
        end else if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (dc == 2'b10) begin
            q = a / b;
            r = a % b;
            return {r, q};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'h0, 32'h8000_0000};
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q  = iq;
            r  = ir;
            return {r, q};
        end
    endfunction

    // One operation: issue, watch busy, compare completion against the model.
    // we_acc: MTHI/MTLO strobes coincide with the accept edge.
    // inj_at/rst_at/cxl_at: busy-cycle index for a stray command, an
    // asynchronous reset, or a cancel (0 = not used).
    task automatic run_op(input string tag, input logic [1:0] mc, input logic [1:0] dc,
                          input logic [31:0] a, input logic [31:0] b, input bit we_acc,
                          input int inj_at, input int rst_at, input int cxl_at);
        logic [31:0] old_hi, old_lo;
        logic [63:0] exp;
        int          lat, n;
        bit          held;
        exp = model(mc, dc, a, b);
        lat = (mc == 2'b01 || mc == 2'b10) ? MUL_LAT : DIV_LAT;
        @(negedge clk);
        old_hi  = hi;
        old_lo  = lo;
        mul_con = mc;
        div_con = dc;
        rs      = a;
        rt      = b;
        if (we_acc) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'h5555_5555;
        end
        @(negedge clk);
        mul_con = 2'b00;
        div_con = 2'b00;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        rs      = $urandom;
        rt      = $urandom;
        n       = 0;
        held    = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (hi !== old_hi || lo !== old_lo || done !== 1'b0) held = 1'b0;
            if (n == inj_at) begin
                mul_con = 2'b01;
                div_con = 2'b10;
                hi_we   = 1'b1;
                lo_we   = 1'b1;
                wdata   = 32'h0000_1234;
            end
            if (n == rst_at) begin
                #2 resetn = 1'b0;
                #1;
                check({tag, "/rst_hi"}, 64'(hi), 64'd0);
                check({tag, "/rst_lo"}, 64'(lo), 64'd0);
                check({tag, "/rst_busy"}, 64'(busy), 64'd0);
                check({tag, "/rst_done"}, 64'(done), 64'd0);
                @(negedge clk);
                check({tag, "/rst_hold_busy"}, 64'(busy), 64'd0);
                resetn = 1'b1;
                return;
            end
            if (n == cxl_at) cancel = 1'b1;
            @(negedge clk);
            mul_con = 2'b00;
            div_con = 2'b00;
            hi_we   = 1'b0;
            lo_we   = 1'b0;
            cancel  = 1'b0;
            if (cxl_at > 0 && n == cxl_at) begin
                check({tag, "/cxl_busy"}, 64'(busy), 64'd0);
                check({tag, "/cxl_hi"}, 64'(hi), 64'(old_hi));
                check({tag, "/cxl_lo"}, 64'(lo), 64'(old_lo));
                check({tag, "/cxl_done"}, 64'(done), 64'd0);
                @(negedge clk);
                check({tag, "/cxl_done_late"}, 64'(done), 64'd0);
                return;
            end
        end
        check({tag, "/busy_len"}, 64'(n), 64'(lat));
        check({tag, "/hold"}, 64'(held), 64'd1);
        check({tag, "/done"}, 64'(done), 64'd1);
        check({tag, "/hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, "/lo"}, 64'(lo), 64'(exp[31:0]));
        @(negedge clk);
        check({tag, "/done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]  mc, dc;
        logic [31:0] a, b;
        int          kind;

        resetn  = 1'b1;
        cancel  = 1'b0;
        mul_con = 2'b00;
        div_con = 2'b00;
        rs      = '0;
        rt      = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;

        // Reset state
        #2 resetn = 1'b0;
        #1;
        check("reset/hi", 64'(hi), 64'd0);
        check("reset/lo", 64'(lo), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed arithmetic cases
        run_op("mult_neg2x3", 2'b01, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 0, 0, 0);
        check("mult_neg2x3/hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg2x3/lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
        run_op("multu_max", 2'b10, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        check("multu_max/hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        run_op("div_neg7_2", 2'b00, 2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0, 0);
        check("div_neg7_2/lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        run_op("divu_by0", 2'b00, 2'b10, 32'd100, 32'd0, 1'b0, 0, 0, 0);
        check("divu_by0/hi_const", 64'(hi), 64'd100);
        run_op("div_by0_neg", 2'b00, 2'b01, 32'hFFFF_FF00, 32'd0, 1'b0, 0, 0, 0);
        run_op("div_ovf", 2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        check("div_ovf/lo_const", 64'(lo), 64'h0000_0000_8000_0000);

        // MTHI/MTLO while idle, both together then LO alone
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both/hi", 64'(hi), 64'h0000_0000_CAFE_0001);
        check("mt_both/lo", 64'(lo), 64'h0000_0000_CAFE_0001);
        lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo/hi", 64'(hi), 64'h0000_0000_CAFE_0001);
        check("mtlo/lo", 64'(lo), 64'h0000_0000_0BAD_F00D);

        // Collisions: mul+div same cycle, write coincident with accept
        run_op("mul_div_both", 2'b01, 2'b01, 32'd1234, 32'hFFFF_FF85, 1'b0, 0, 0, 0);
        run_op("we_at_accept", 2'b10, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 0, 0);
        run_op("div_we_accept", 2'b00, 2'b10, 32'hDEAD_BEEF, 32'd13, 1'b1, 0, 0, 0);

        // Stray command and MTLO mid-divide are ignored; then reset mid-divide
        run_op("div_inject", 2'b00, 2'b01, 32'd1000, 32'hFFFF_FFF9, 1'b0, 10, 0, 0);
        run_op("div_reset", 2'b00, 2'b01, 32'd1000, 32'hFFFF_FFF9, 1'b0, 0, 20, 0);
        run_op("after_reset", 2'b00, 2'b10, 32'd77, 32'd5, 1'b0, 0, 0, 0);

`ifdef MULDIV_CANCEL_EN
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        hi_we = 1'b0;
        check("cxl/preload", 64'(hi), 64'h0000_0000_0000_AAAA);
        run_op("cxl_divu", 2'b00, 2'b10, 32'd50, 32'd7, 1'b0, 0, 0, 5);
        check("cxl/hi_kept", 64'(hi), 64'h0000_0000_0000_AAAA);
        run_op("cxl_mul", 2'b01, 2'b00, 32'd9, 32'd9, 1'b0, 0, 0, 1);
        run_op("cxl_after", 2'b00, 2'b10, 32'd50, 32'd7, 1'b0, 0, 0, 0);
`endif

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 3);
            mc   = (kind == 0) ? 2'b01 : (kind == 1) ? 2'b10 : 2'b00;
            dc   = (kind == 2) ? 2'b01 : (kind == 3) ? 2'b10 : 2'b00;
            a    = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0 - $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op("random", mc, dc, a, b, 1'b0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- HI/LO multiply/divide unit that receives the mul_con/div_con commands and operands driven by the execute stage.
- Multiply is pipelined over a fixed latency; divide is iterative (radix-2 restoring, 32 steps plus a sign-fix cycle).
- Owns the architectural HI and LO registers, and services MTHI/MTLO writes.
- Drives a busy signal that the hazard unit ORs into the pipeline stall.

Parameters:
- MUL_LAT, 2, multiply busy cycles between accept and HI/LO update (legal range 1..4).
- DIV_STEPS, 32, divide iteration count; fixed to the operand width, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- mul_con  in  2  00 none, 01 MULT (signed), 10 MULTU, 11 ignored
- div_con  in  2  00 none, 01 DIV (signed), 10 DIVU, 11 ignored
- rs  in  32  operand A (dividend / multiplicand)
- rt  in  32  operand B (divisor / multiplier)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  32  MTHI/MTLO data
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight; HI/LO not yet valid
- done  out  1  one-cycle pulse on the cycle after HI/LO update

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - hi, lo, busy, done all return to 0.
  - FSM returns to IDLE and the iteration counter clears.
  - Any in-flight operation is discarded.
- FSM states and transitions:
  - IDLE: accept on an edge where mul_con or div_con is 01 or 10.
  - MUL: counter runs MUL_LAT-1 down to 0; HI/LO written on the last edge.
  - DIV: 32 restoring steps, one quotient bit per cycle, MSB first.
  - FIX: signed sign correction; HI/LO written on this edge, then return to IDLE.
- Command rules:
  - Commands are single-cycle pulses; the execute stage zeroes con while stalled.
  - Operands are latched on the accept edge; rs/rt are don't-care afterwards.
  - mul_con and div_con both valid in the same cycle: multiply wins, divide dropped.
  - Command arriving while busy=1: ignored, with no state change.
- Busy and done timing:
  - busy rises on the cycle after accept.
  - busy is high for MUL_LAT cycles (multiply) or 33 cycles (divide).
  - busy falls in the same cycle hi/lo show the new value; done pulses in that cycle.
- Multiply:
  - MULT sign-extends to 33 bits; MULTU zero-extends.
  - {hi,lo} = low 64 bits of the product.
- Divide:
  - Operates on magnitudes.
  - lo = quotient, negated when sign(rs)^sign(rt) (signed only).
  - hi = remainder, negated when sign(rs) (signed only).
  - DIVU skips the FIX sign correction; the FIX cycle still elapses, so latency stays 33.
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
  - Divide by zero (signed or unsigned): normal latency, lo=0xFFFFFFFF, hi=rs; no exception.
- MTHI/MTLO:
  - When IDLE, hi_we/lo_we write wdata on the edge; both may write in the same cycle.
  - When busy, the writes are dropped.
  - Write coincident with an accepted command: command wins, write dropped.
- hi and lo are registered outputs; they hold their old value throughout an operation.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- When defined, adds input cancel (1 bit), driven when the instruction that issued the command takes an exception.
- cancel=1 in any non-IDLE state: FSM returns to IDLE on the next edge.
  - busy clears and HI/LO are left unchanged.
  - done is not pulsed.
- cancel=1 in IDLE has no effect, and cancel takes priority over a same-cycle completion.
- Without the macro, the port is absent and every accepted operation runs to completion.

Decomposition:
- Shared package holds:
  - con encodings: CON_NONE=2'b00, CON_SIGNED=2'b01, CON_UNSIGNED=2'b10.
  - FSM state encoding: IDLE, MUL, DIV, FIX.
  - DIV_STEPS, and the divide-by-zero result constant for lo.
- One natural sub-module, div_iter: a 32-step restoring datapath holding remainder/quotient shift registers and the step counter.
  - Handshake: start/busy/done.
  - The top level owns the FSM, the multiply pipeline, HI/LO and the sign fix.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after MUL_LAT busy cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one pulse.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy exactly 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=100, rt=0 -> 33 busy cycles, lo=0xFFFFFFFF, hi=100; also run DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-divide (cycle 10): pulse mul_con=01 plus lo_we=1 with wdata=0x1234 -> both ignored, divide result unchanged.
  - Then deassert resetn at cycle 20 -> hi=lo=0, busy=0 immediately without a clock edge.
- With MULDIV_CANCEL_EN: preload hi=0xAAAA via MTHI, start DIVU 50/7, cancel at cycle 5 -> busy low next cycle, hi=0xAAAA, no done pulse.
